// File: rtl/fifo_stream_checker.sv
// Multi-channel stream-integrity monitor for FIFO read/write data paths.
// Each channel compares every accepted word with the previous accepted word
// on the same channel. Mode 0 flags duplicates. Mode 1 flags breaks in a +1
// sequence, where a wrap from all-ones to zero is legal. Modes 2 and 3 only
// count words.
//
// Ports:
//   clk_i        system clock, rising edge
//   resetn_i     synchronous active-low reset
//   data_i       channel c word at [c*DATA_W +: DATA_W]
//   strobe_i     channel c word valid, one word per high cycle
//   mode_i       0 duplicate check, 1 increment check, 2/3 count only
//   clear_i      synchronous clear of counters, flags, captures and history
//   err_pulse_o  one-cycle error indication per channel
//   err_sticky_o error seen since the last clear or reset
//   word_cnt_o   accepted words per channel, saturating
//   err_cnt_o    errors per channel, saturating
//   cap_valid_o  first-error capture valid
//   cap_prev_o   previous word at the first error
//   cap_curr_o   offending word at the first error
//
// Pipeline: stage 1 registers the inputs. Stage 2 compares each word with its
// history and updates the history. Stage 3 updates the counters, the flags
// and the capture. A word strobed at edge N is reported at edge N+2.
module fifo_stream_checker #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                       clk_i,
   input  logic                       resetn_i,
   input  logic [NUM_CH*DATA_W-1:0]   data_i,
   input  logic [NUM_CH-1:0]          strobe_i,
   input  logic [1:0]                 mode_i,
   input  logic                       clear_i,
   output logic [NUM_CH-1:0]          err_pulse_o,
   output logic [NUM_CH-1:0]          err_sticky_o,
   output logic [NUM_CH*CNT_W-1:0]    word_cnt_o,
   output logic [NUM_CH*CNT_W-1:0]    err_cnt_o,
   output logic [NUM_CH-1:0]          cap_valid_o,
   output logic [NUM_CH*DATA_W-1:0]   cap_prev_o,
   output logic [NUM_CH*DATA_W-1:0]   cap_curr_o
);

   localparam int unsigned BUS_W = NUM_CH * DATA_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic               flush;
   logic [BUS_W-1:0]   s1_data;
   logic [NUM_CH-1:0]  s1_vld;
   logic [1:0]         s1_mode;
   logic [BUS_W-1:0]   prev;
   logic [NUM_CH-1:0]  has_prev;
   logic [NUM_CH-1:0]  cmp_err;
   logic [NUM_CH-1:0]  s2_vld;
   logic [NUM_CH-1:0]  s2_err;
   logic [BUS_W-1:0]   s2_data;
   logic [BUS_W-1:0]   s2_prev;
   logic [NUM_CH-1:0]  err_hit;

   // Reset and clear empty the pipeline and wipe all state alike.
   assign flush = !resetn_i || clear_i;

   // Stage 1 valid; words strobed in a clear cycle are dropped here.
   always_ff @(posedge clk_i) begin
      if (flush) s1_vld <= '0;
      else       s1_vld <= strobe_i;
   end

   // Stage 1 payload, qualified by s1_vld.
   always_ff @(posedge clk_i) begin
      s1_data <= data_i;
      s1_mode <= mode_i;
   end

   // Per-channel compare of the stage-1 word against the history word.
   always_comb begin
      cmp_err = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (s1_vld[c] && has_prev[c]) begin
            case (s1_mode)
               2'd0: cmp_err[c] = (s1_data[c*DATA_W +: DATA_W] == prev[c*DATA_W +: DATA_W]);
               2'd1: cmp_err[c] = (s1_data[c*DATA_W +: DATA_W] != (prev[c*DATA_W +: DATA_W] + DATA_W'(1)));
               default: cmp_err[c] = 1'b0;
            endcase
         end
      end
   end

   // Stage 2: history update; prev follows every accepted word, good or bad.
   always_ff @(posedge clk_i) begin
      if (flush) begin
         s2_vld   <= '0;
         s2_err   <= '0;
         has_prev <= '0;
         prev     <= '0;
      end else begin
         s2_vld <= s1_vld;
         s2_err <= cmp_err;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (s1_vld[c]) begin
               prev[c*DATA_W +: DATA_W] <= s1_data[c*DATA_W +: DATA_W];
               has_prev[c]              <= 1'b1;
            end
         end
      end
   end

   // Stage 2 capture candidates, qualified by s2_vld/s2_err.
   always_ff @(posedge clk_i) begin
      s2_data <= s1_data;
      s2_prev <= prev;
   end

   assign err_hit = s2_vld & s2_err;

   // Stage 3: counters, flags and first-error capture.
   always_ff @(posedge clk_i) begin
      if (flush) begin
         err_pulse_o  <= '0;
         err_sticky_o <= '0;
         word_cnt_o   <= '0;
         err_cnt_o    <= '0;
         cap_valid_o  <= '0;
         cap_prev_o   <= '0;
         cap_curr_o   <= '0;
      end else begin
         err_pulse_o  <= err_hit;
         err_sticky_o <= err_sticky_o | err_hit;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (s2_vld[c] && (word_cnt_o[c*CNT_W +: CNT_W] != CNT_MAX))
               word_cnt_o[c*CNT_W +: CNT_W] <= word_cnt_o[c*CNT_W +: CNT_W] + CNT_W'(1);
            if (err_hit[c] && (err_cnt_o[c*CNT_W +: CNT_W] != CNT_MAX))
               err_cnt_o[c*CNT_W +: CNT_W] <= err_cnt_o[c*CNT_W +: CNT_W] + CNT_W'(1);
            // Only the first error since clear is kept.
            if (err_hit[c] && !cap_valid_o[c]) begin
               cap_valid_o[c]                 <= 1'b1;
               cap_prev_o[c*DATA_W +: DATA_W] <= s2_prev[c*DATA_W +: DATA_W];
               cap_curr_o[c*DATA_W +: DATA_W] <= s2_data[c*DATA_W +: DATA_W];
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_stream_checker.sv
// Self-checking bench for fifo_stream_checker. Two instances share all inputs:
// one has 16-bit counters and the other has 4-bit counters, which exercises
// saturation. A behavioural model tracks each channel's history, counts and
// first-error capture, and predicts the error pulse two edges after sampling.
module tb_fifo_stream_checker;

   localparam int unsigned DW  = 32;
   localparam int unsigned NC  = 2;
   localparam int unsigned CW  = 16;
   localparam int unsigned CWS = 4;

   logic              clk = 1'b0;
   logic              resetn;
   logic              clear;
   logic [NC*DW-1:0]  data;
   logic [NC-1:0]     strobe;
   logic [1:0]        mode;

   logic [NC-1:0]     a_pulse, a_sticky, a_capv;
   logic [NC*CW-1:0]  a_wcnt, a_ecnt;
   logic [NC*DW-1:0]  a_capp, a_capc;
   logic [NC-1:0]     s_pulse, s_sticky, s_capv;
   logic [NC*CWS-1:0] s_wcnt, s_ecnt;
   logic [NC*DW-1:0]  s_capp, s_capc;

   always #5 clk = ~clk;

   fifo_stream_checker #(.DATA_W(DW), .NUM_CH(NC), .CNT_W(CW)) dut (
      .clk_i(clk), .resetn_i(resetn), .data_i(data), .strobe_i(strobe),
      .mode_i(mode), .clear_i(clear), .err_pulse_o(a_pulse), .err_sticky_o(a_sticky),
      .word_cnt_o(a_wcnt), .err_cnt_o(a_ecnt), .cap_valid_o(a_capv),
      .cap_prev_o(a_capp), .cap_curr_o(a_capc));

   fifo_stream_checker #(.DATA_W(DW), .NUM_CH(NC), .CNT_W(CWS)) dut_sat (
      .clk_i(clk), .resetn_i(resetn), .data_i(data), .strobe_i(strobe),
      .mode_i(mode), .clear_i(clear), .err_pulse_o(s_pulse), .err_sticky_o(s_sticky),
      .word_cnt_o(s_wcnt), .err_cnt_o(s_ecnt), .cap_valid_o(s_capv),
      .cap_prev_o(s_capp), .cap_curr_o(s_capc));

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state, per channel.
   logic [DW-1:0] m_prev [NC];
   bit            m_has  [NC];
   int            m_words[NC];
   int            m_errs [NC];
   bit            m_capv [NC];
   logic [DW-1:0] m_capp [NC];
   logic [DW-1:0] m_capc [NC];
   logic [NC-1:0] pq[$];   // expected pulse per edge, consumed two edges later

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   function automatic void model_clear();
      for (int c = 0; c < NC; c++) begin
         m_prev[c] = '0; m_has[c] = 0; m_words[c] = 0; m_errs[c] = 0;
         m_capv[c] = 0; m_capp[c] = '0; m_capc[c] = '0;
      end
   endfunction

   // One clock: drive inputs, advance the model, check the pulse outputs.
   task automatic step(input logic [NC-1:0] stb, input logic [DW-1:0] d0,
                       input logic [DW-1:0] d1, input logic clr);
      logic [DW-1:0] d[NC];
      logic [DW-1:0] nxt;
      logic [NC-1:0] e;
      logic [NC-1:0] exp_p;
      d[0] = d0; d[1] = d1;
      strobe = stb; data = {d1, d0}; clear = clr;
      @(posedge clk);
      e = '0;
      if (clr) begin
         model_clear();
         pq.delete();
         pq.push_back('0); pq.push_back('0); pq.push_back('0);
      end else begin
         for (int c = 0; c < NC; c++) begin
            if (stb[c]) begin
               m_words[c]++;
               nxt = m_prev[c] + 1'b1;
               if (m_has[c]) begin
                  if (mode == 2'd0 && d[c] == m_prev[c]) e[c] = 1'b1;
                  if (mode == 2'd1 && d[c] != nxt)       e[c] = 1'b1;
               end
               if (e[c]) begin
                  m_errs[c]++;
                  if (!m_capv[c]) begin
                     m_capv[c] = 1; m_capp[c] = m_prev[c]; m_capc[c] = d[c];
                  end
               end
               m_has[c]  = 1;
               m_prev[c] = d[c];
            end
         end
         pq.push_back(e);
      end
      #1;
      exp_p = pq.pop_front();
      n_cmp++;
      if (a_pulse !== exp_p) begin
         n_bad++;
         $display("FAIL pulse16 t=%0t got=%b exp=%b", $time, a_pulse, exp_p);
      end
      n_cmp++;
      if (s_pulse !== exp_p) begin
         n_bad++;
         $display("FAIL pulse4 t=%0t got=%b exp=%b", $time, s_pulse, exp_p);
      end
   endtask

   task automatic drain();
      step('0, '0, '0, 1'b0);
      step('0, '0, '0, 1'b0);
   endtask

   // Compare all per-channel status outputs of both instances with the model.
   task automatic check_state(input string tag);
      logic [CW-1:0]  ew, ee;
      logic [CWS-1:0] sw, se;
      for (int c = 0; c < NC; c++) begin
         ew = CW'(sat(m_words[c], CW));   ee = CW'(sat(m_errs[c], CW));
         sw = CWS'(sat(m_words[c], CWS)); se = CWS'(sat(m_errs[c], CWS));
         n_cmp += 12;
         if (a_wcnt[c*CW +: CW] !== ew) begin n_bad++; $display("FAIL %s wcnt16 ch%0d got=%0d exp=%0d", tag, c, a_wcnt[c*CW +: CW], ew); end
         if (a_ecnt[c*CW +: CW] !== ee) begin n_bad++; $display("FAIL %s ecnt16 ch%0d got=%0d exp=%0d", tag, c, a_ecnt[c*CW +: CW], ee); end
         if (a_sticky[c] !== (m_errs[c] > 0)) begin n_bad++; $display("FAIL %s sticky16 ch%0d got=%b exp=%b", tag, c, a_sticky[c], m_errs[c] > 0); end
         if (a_capv[c] !== m_capv[c]) begin n_bad++; $display("FAIL %s capv16 ch%0d got=%b exp=%b", tag, c, a_capv[c], m_capv[c]); end
         if (a_capp[c*DW +: DW] !== m_capp[c]) begin n_bad++; $display("FAIL %s capp16 ch%0d got=%h exp=%h", tag, c, a_capp[c*DW +: DW], m_capp[c]); end
         if (a_capc[c*DW +: DW] !== m_capc[c]) begin n_bad++; $display("FAIL %s capc16 ch%0d got=%h exp=%h", tag, c, a_capc[c*DW +: DW], m_capc[c]); end
         if (s_wcnt[c*CWS +: CWS] !== sw) begin n_bad++; $display("FAIL %s wcnt4 ch%0d got=%0d exp=%0d", tag, c, s_wcnt[c*CWS +: CWS], sw); end
         if (s_ecnt[c*CWS +: CWS] !== se) begin n_bad++; $display("FAIL %s ecnt4 ch%0d got=%0d exp=%0d", tag, c, s_ecnt[c*CWS +: CWS], se); end
         if (s_sticky[c] !== (m_errs[c] > 0)) begin n_bad++; $display("FAIL %s sticky4 ch%0d got=%b exp=%b", tag, c, s_sticky[c], m_errs[c] > 0); end
         if (s_capv[c] !== m_capv[c]) begin n_bad++; $display("FAIL %s capv4 ch%0d got=%b exp=%b", tag, c, s_capv[c], m_capv[c]); end
         if (s_capp[c*DW +: DW] !== m_capp[c]) begin n_bad++; $display("FAIL %s capp4 ch%0d got=%h exp=%h", tag, c, s_capp[c*DW +: DW], m_capp[c]); end
         if (s_capc[c*DW +: DW] !== m_capc[c]) begin n_bad++; $display("FAIL %s capc4 ch%0d got=%h exp=%h", tag, c, s_capc[c*DW +: DW], m_capc[c]); end
      end
   endtask

   task automatic do_reset(input int cycles);
      resetn = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         strobe = NC'($urandom); data = {$urandom, $urandom}; clear = 1'b0;
         @(posedge clk);
         #1;
         n_cmp++;
         if (a_pulse !== '0 || s_pulse !== '0) begin
            n_bad++;
            $display("FAIL reset_pulse got=%b/%b exp=0", a_pulse, s_pulse);
         end
      end
      resetn = 1'b1;
      strobe = '0;
      model_clear();
      pq.delete();
      pq.push_back('0); pq.push_back('0);
      check_state("reset");
   endtask

   task automatic test_reset();
      do_reset(3);
      for (int i = 0; i < 10; i++) begin
         step('0, '0, '0, 1'b0);
         check_state("idle");
      end
   endtask

   task automatic test_dup();
      mode = 2'd0;
      step('0, '0, '0, 1'b1);
      step(2'b01, 32'd5, '0, 1'b0);
      step(2'b01, 32'd6, '0, 1'b0);
      step(2'b01, 32'd6, '0, 1'b0);
      step(2'b01, 32'd7, '0, 1'b0);
      drain();
      check_state("dup");
      n_cmp += 4;
      if (a_ecnt[CW-1:0] !== CW'(1)) begin n_bad++; $display("FAIL dup_ecnt got=%0d exp=1", a_ecnt[CW-1:0]); end
      if (a_wcnt[CW-1:0] !== CW'(4)) begin n_bad++; $display("FAIL dup_wcnt got=%0d exp=4", a_wcnt[CW-1:0]); end
      if (a_capp[DW-1:0] !== 32'd6 || a_capc[DW-1:0] !== 32'd6) begin n_bad++; $display("FAIL dup_cap got=%0d/%0d exp=6/6", a_capp[DW-1:0], a_capc[DW-1:0]); end
      if (a_wcnt[2*CW-1:CW] !== '0) begin n_bad++; $display("FAIL dup_ch1 got=%0d exp=0", a_wcnt[2*CW-1:CW]); end
   endtask

   task automatic test_inc_wrap();
      mode = 2'd1;
      step('0, '0, '0, 1'b1);
      step(2'b01, 32'hFFFF_FFFE, '0, 1'b0);
      step(2'b01, 32'hFFFF_FFFF, '0, 1'b0);
      step(2'b01, 32'h0, '0, 1'b0);
      step(2'b01, 32'h2, '0, 1'b0);
      drain();
      check_state("inc_wrap");
      step(2'b01, 32'd9, '0, 1'b0);
      drain();
      check_state("inc_late");
      n_cmp += 2;
      if (a_ecnt[CW-1:0] !== CW'(2)) begin n_bad++; $display("FAIL inc_ecnt got=%0d exp=2", a_ecnt[CW-1:0]); end
      if (a_capp[DW-1:0] !== 32'd0 || a_capc[DW-1:0] !== 32'd2) begin n_bad++; $display("FAIL inc_cap got=%0d/%0d exp=0/2", a_capp[DW-1:0], a_capc[DW-1:0]); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] b0, b1;
      int skip;
      mode = 2'd1;
      step('0, '0, '0, 1'b1);
      b0 = $urandom; b1 = $urandom; skip = int'($urandom_range(100, 900));
      for (int i = 0; i < 1000; i++)
         step(2'b11, b0 + DW'(i), b1 + DW'(i) + DW'(i >= skip), 1'b0);
      drain();
      check_state("b2b");
      n_cmp += 3;
      if (a_ecnt !== {CW'(1), CW'(0)}) begin n_bad++; $display("FAIL b2b_ecnt got=%h exp=00010000", a_ecnt); end
      if (a_wcnt !== {CW'(1000), CW'(1000)}) begin n_bad++; $display("FAIL b2b_wcnt got=%h", a_wcnt); end
      if (a_sticky !== 2'b10) begin n_bad++; $display("FAIL b2b_sticky got=%b exp=10", a_sticky); end
   endtask

   task automatic test_saturation();
      mode = 2'd0;
      step('0, '0, '0, 1'b1);
      for (int i = 0; i < 20; i++) step(2'b01, 32'd3, '0, 1'b0);
      drain();
      check_state("sat");
      n_cmp += 2;
      if (s_wcnt[CWS-1:0] !== 4'd15) begin n_bad++; $display("FAIL sat_wcnt got=%0d exp=15", s_wcnt[CWS-1:0]); end
      if (s_ecnt[CWS-1:0] !== 4'd15) begin n_bad++; $display("FAIL sat_ecnt got=%0d exp=15", s_ecnt[CWS-1:0]); end
   endtask

   task automatic test_clear_dup();
      mode = 2'd0;
      step('0, '0, '0, 1'b1);
      step(2'b01, 32'd3, '0, 1'b0);
      step(2'b01, 32'd3, '0, 1'b0);
      step('0, '0, '0, 1'b1);     // duplicate is in its compare stage here
      drain();
      check_state("clr_dup");
      n_cmp++;
      if (a_capv !== '0 || a_wcnt !== '0) begin n_bad++; $display("FAIL clr_state capv=%b wcnt=%h exp=0", a_capv, a_wcnt); end
      step(2'b01, 32'd3, '0, 1'b0);
      step(2'b01, 32'd3, '0, 1'b0);
      drain();
      check_state("clr_after");
      n_cmp++;
      if (a_ecnt[CW-1:0] !== CW'(1)) begin n_bad++; $display("FAIL clr_ecnt got=%0d exp=1", a_ecnt[CW-1:0]); end
   endtask

   task automatic test_random();
      logic [DW-1:0] last[NC];
      logic [DW-1:0] v[NC];
      last[0] = '0; last[1] = '0;
      for (int chunk = 0; chunk < 40; chunk++) begin
         mode = 2'($urandom_range(0, 3));
         if (chunk % 10 == 5) do_reset(2);
         for (int i = 0; i < 50; i++) begin
            for (int c = 0; c < NC; c++) begin
               v[c] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : last[c] + 1'b1;
               last[c] = v[c];
            end
            step(NC'($urandom), v[0], v[1], ($urandom_range(0, 49) == 0));
         end
         drain();
         check_state("random");
      end
   endtask

   initial begin
      resetn = 1'b0; clear = 1'b0; strobe = '0; data = '0; mode = 2'd0;
      model_clear();
      test_reset();
      test_dup();
      test_inc_wrap();
      test_back_to_back();
      test_saturation();
      test_clear_dup();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fifo_stream_checker.md
Name: fifo_stream_checker

Overview:
- Multi-channel, parametrised stream-integrity monitor for FIFO read/write data paths in the Aurora FPGA.
- Each channel samples data on its strobe and compares each word with the previous accepted word on that channel.
- Detects duplicate words (mode 0) or breaks in a +1 incrementing sequence (mode 1).
- Keeps saturating word and error counters, a sticky error flag and a first-error capture per channel, for the debug core and for register readout.

Parameters:
DATA_W, 32, data word width per channel (>=2)
NUM_CH, 2, number of monitored channels (>=1)
CNT_W, 16, width of the word and error counters

Ports:
clk_i  input  1  system clock; all logic on the rising edge
resetn_i  input  1  synchronous, active-low reset
data_i  input  NUM_CH*DATA_W  channel c data at [c*DATA_W +: DATA_W]
strobe_i  input  NUM_CH  channel c word valid (FIFO rd_en or wr_en), one word per high cycle
mode_i  input  2  0=duplicate check, 1=increment check, 2/3=count only, no checking
clear_i  input  1  synchronous clear of all counters, sticky flags, captures and history
err_pulse_o  output  NUM_CH  one-cycle error indication per channel
err_sticky_o  output  NUM_CH  set on the first error, held until clear or reset
word_cnt_o  output  NUM_CH*CNT_W  accepted words per channel, saturating
err_cnt_o  output  NUM_CH*CNT_W  errors per channel, saturating
cap_valid_o  output  NUM_CH  first-error capture valid
cap_prev_o  output  NUM_CH*DATA_W  previous word at the first error
cap_curr_o  output  NUM_CH*DATA_W  offending word at the first error

Behaviour:
- Reset (resetn_i=0 at an edge): every output goes to 0, every pipeline valid goes to 0, and has_prev[c] goes to 0 for all channels.
- Stage 1: data_i, strobe_i and mode_i are registered unconditionally, which gives s1_data, s1_vld and s1_mode.
- Stage 2, per channel, when s1_vld=1:
  - word_cnt increments and saturates at 2^CNT_W-1.
  - If has_prev=0: store the word as prev, set has_prev=1, flag no error.
  - Else compare the word with prev:
    - mode 0: error if s1_data == prev.
    - mode 1: error if s1_data != (prev+1) mod 2^DATA_W. Wrap from all-ones to 0 is legal.
    - mode 2/3: never an error.
  - prev is then updated to s1_data, whether or not the word was an error.
- On an error:
  - err_pulse_o[c]=1 for exactly one cycle.
  - err_sticky_o[c]=1.
  - err_cnt increments and saturates.
  - If cap_valid_o[c]=0, load cap_prev and cap_curr and set cap_valid_o[c]=1. Later errors do not overwrite the capture.
- Latency: strobe at edge N is counted and flagged at edge N+2 (err_pulse_o high during the cycle after edge N+2). Back-to-back strobes are supported every cycle with no bubbles.
- Channels are fully independent. Simultaneous strobes on all channels are processed in parallel.
- clear_i=1 at an edge:
  - Clears counters, sticky flags, captures, has_prev and both pipeline valids.
  - clear_i takes priority over a stage-2 word in the same cycle; that word is discarded and not counted.
  - Words strobed in the clear cycle are also dropped. The first word after clear re-seeds the history.
- Reset mid-stream behaves like clear, plus outputs to 0.
- Mode changes take effect for words whose stage-1 sample has the new mode. Software issues clear_i when changing mode; without it, the first compare uses the old history.
- Saturated counters hold their maximum value; err_pulse_o and err_sticky_o continue to operate.
- Data equality and increment arithmetic are exactly DATA_W bits wide. No sign semantics.

Test Plan:
- Reset/idle: hold resetn_i=0 for 3 cycles, then release with strobe_i=0 -> all outputs 0 for 10 cycles.
- Mode 0, channel 0 words 5,6,6,7 on consecutive cycles -> single err_pulse_o[0] 2 cycles after the third word; err_cnt=1, word_cnt=4, cap_prev=6, cap_curr=6; channel 1 untouched.
- Mode 1, words 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x2 -> no error on the wrap; error on 0x2 with cap_prev=0, cap_curr=2; a later bad word 9 leaves the capture unchanged and gives err_cnt=2.
- Both channels strobed together for 1000 cycles in mode 1, channel 1 with one skipped value -> only channel 1 errors, err_cnt[1]=1, word_cnt=1000 on both.
- CNT_W=4, mode 0, 20 repeats of value 3 -> word_cnt=15, err_cnt=15 (saturated); err_pulse_o still fires for each repeat.
- clear_i asserted in the same cycle as a stage-2 duplicate -> no pulse, counters 0, cap_valid_o=0; next word 3, then 3 -> exactly one error.
